ast_width_reducer: RTL and testbench
====================================

# ast_width_reducer

Avalon-ST width reducer: accepts wide beats (default 256 bit) and re-emits each as a sequence of narrow beats (default 64 bit), preserving packet framing, empty and channel. It is the downstream counterpart of `ast_width_extender`. It sits after the wide-datapath processing and returns the stream to the native narrow interface.

## Interface
- `DATA_IN_W`, 256, input data width; a multiple of `DATA_OUT_W`; `DATA_IN_W / DATA_OUT_W` ≥ 2.
- `EMPTY_IN_W`, `$clog2(DATA_IN_W/8)` (min 1), input empty width.
- `CHANNEL_W`, 10, channel width.
- `DATA_OUT_W`, 64, output data width; a multiple of 8.
- `EMPTY_OUT_W`, `$clog2(DATA_OUT_W/8)` (min 1), output empty width.
- `clk_i` in 1: the single clock.
- `srst_i` in 1: reset, synchronous and active-high.
- `ast_data_i` in `DATA_IN_W`: wide data; word 0 is `[DATA_OUT_W-1:0]` and is sent first.
- `ast_startofpacket_i`, `ast_endofpacket_i`, `ast_valid_i` in 1: input framing and valid.
- `ast_empty_i` in `EMPTY_IN_W`: unused bytes at the top of an eop beat.
- `ast_channel_i` in `CHANNEL_W`: input channel.
- `ast_ready_o` out 1: input ready.
- `ast_data_o` out `DATA_OUT_W`: narrow data.
- `ast_startofpacket_o`, `ast_endofpacket_o`, `ast_valid_o` out 1: output framing and valid.
- `ast_empty_o` out `EMPTY_OUT_W`: unused top bytes on the eop word.
- `ast_channel_o` out `CHANNEL_W`: output channel.
- `ast_ready_i` in 1: downstream ready.

## Operation
- Derived constants:
  - `RATIO = DATA_IN_W/DATA_OUT_W`.
  - `IN_BYTES = DATA_IN_W/8`.
  - `OUT_BYTES = DATA_OUT_W/8`.
- Handshakes:
  - Input beat accepted when `ast_valid_i && ast_ready_o`.
  - Output word transferred when `ast_valid_o && ast_ready_i`.
- On accept, the block captures into a holding register: data, sop, eop, empty and channel.
  - `words` = `RATIO` when eop = 0.
  - `words` = ceil(`valid_bytes` / `OUT_BYTES`) when eop = 1, where `valid_bytes` = `IN_BYTES − ast_empty_i` (range 1..`IN_BYTES`).
  - `ast_empty_i` is ignored on non-eop beats.
- State machine:
  - `IDLE`: holding register empty.
  - `SEND`: word index `idx` from 0 to `words−1`.
  - `IDLE` → `SEND` on accept, with `idx` = 0.
  - In `SEND`, each output transfer increments `idx`.
  - On transfer of word `words−1`: go to `SEND` with `idx` = 0 if an input beat is accepted in the same cycle; otherwise go to `IDLE`.
- `ast_ready_o` = (state == `IDLE`) || (`idx == words−1` && `ast_ready_i`). This is combinational from registered state plus `ast_ready_i`.
- Output word `idx` = held data bits `[idx*DATA_OUT_W +: DATA_OUT_W]`.
- Output framing:
  - `ast_startofpacket_o` = held sop && `idx == 0`.
  - `ast_endofpacket_o` = held eop && `idx == words−1`.
  - `ast_empty_o` = `words*OUT_BYTES − valid_bytes` on the eop word; 0 otherwise.
- `ast_channel_o` = held channel on every word.
- Data bytes beyond `valid_bytes` on the eop word are passed through unchanged (don't-care).
- The block does not check sop/eop consistency; framing errors propagate as-is.

## Timing
- Reset (`srst_i` high at a clock edge):
  - State → `IDLE`, `idx` = 0.
  - `ast_valid_o` = 0.
  - `ast_data_o`, `ast_empty_o`, `ast_channel_o`, `ast_startofpacket_o`, `ast_endofpacket_o` all = 0.
  - `ast_ready_o` = 1 from the first cycle after reset.
- Reset mid-packet discards the held beat. No partial words appear after reset.
- Latency: word 0 is valid the cycle after input accept.
- Throughput: with `ast_ready_i` held high, one output word per cycle with no bubbles between beats. A wide beat needs `words` cycles.
- Backpressure:
  - While `ast_valid_o` is high and `ast_ready_i` is low, all outputs hold stable.
  - `ast_valid_o` never drops without a transfer.
- An input beat with `ast_valid_i` high and `ast_ready_o` low must be held by the source; nothing is captured.

## Structure
- Package `ast_wr_pkg` holds the state enum `wr_state_t` (`IDLE_S`, `SEND_S`).
  - Width-dependent constants stay as module localparams, because they depend on module parameters.
- No sub-module is needed: a single `always_ff` holds state, `idx`, the holding register and `words`/`last_empty`. Output muxing is combinational from the held registers.
- `words` and the last-word empty are computed once at accept and registered. They are not recomputed per word.

## Test plan
- Single beat, sop=eop=1, empty=0, data `0x…3_2_1_0` words, `ast_ready_i`=1 → 4 words on consecutive cycles; word 0 has sop; word 3 has eop with empty=0; channel constant.
- Eop beat with empty=20 (12 valid bytes) → 2 words; second word eop=1, empty=4; `ast_ready_o` reasserts in the cycle word 1 transfers.
- 3-beat packet (sop, mid, eop with empty=31) → 9 words; last word empty=7; no gaps between beats at full ready.
- `ast_ready_i` toggling at 50% random → output word sequence identical to the full-ready case; outputs stable while stalled.
- Two back-to-back packets on channels 5 and 9 → channel switches exactly at the first word of packet 2; sop/eop counts are 2 each.
- `srst_i` pulsed during word 2 of a 4-word beat → `ast_valid_o`=0 the next cycle; a subsequent fresh packet is output correctly starting at word 0.

Source files
------------

// File: rtl/ast_wr_pkg.sv
// Shared types for the Avalon-ST width reducer.
package ast_wr_pkg;

  typedef enum logic {
    IDLE_S = 1'b0,
    SEND_S = 1'b1
  } wr_state_t;

endpackage

// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: splits each wide beat into up to RATIO narrow words,
// keeping sop/eop/empty/channel framing intact.
module ast_width_reducer
  import ast_wr_pkg::*;
#(
  parameter int DATA_IN_W   = 256,
  parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W/8) > 0) ? $clog2(DATA_IN_W/8) : 1,
  parameter int CHANNEL_W   = 10,
  parameter int DATA_OUT_W  = 64,
  parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W/8) > 0) ? $clog2(DATA_OUT_W/8) : 1
) (
  input  logic                   clk_i,
  input  logic                   srst_i,

  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,

  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int RATIO     = DATA_IN_W / DATA_OUT_W;
  localparam int IN_BYTES  = DATA_IN_W / 8;
  localparam int OUT_BYTES = DATA_OUT_W / 8;
  localparam int IDX_W     = ($clog2(RATIO) > 0) ? $clog2(RATIO) : 1;

  // Index of the final word of a beat (words - 1).
  function automatic logic [IDX_W-1:0] calc_last_idx(
    input logic                  eop,
    input logic [EMPTY_IN_W-1:0] empty
  );
    int vb;
    vb = IN_BYTES - int'(empty);
    if (eop) return IDX_W'((vb - 1) / OUT_BYTES);
    else     return IDX_W'(RATIO - 1);
  endfunction

  // Unused top bytes of the final word: words*OUT_BYTES - valid_bytes.
  function automatic logic [EMPTY_OUT_W-1:0] calc_last_empty(
    input logic                  eop,
    input logic [EMPTY_IN_W-1:0] empty
  );
    int vb;
    vb = IN_BYTES - int'(empty);
    if (eop) return EMPTY_OUT_W'(OUT_BYTES - 1 - ((vb - 1) % OUT_BYTES));
    else     return '0;
  endfunction

  wr_state_t                        r_state;
  wr_state_t                        w_state_nxt;
  logic [IDX_W-1:0]                 r_idx;
  logic [IDX_W-1:0]                 w_idx_nxt;

  logic [RATIO-1:0][DATA_OUT_W-1:0] r_data;
  logic                             r_sop;
  logic                             r_eop;
  logic [CHANNEL_W-1:0]             r_chan;
  logic [IDX_W-1:0]                 r_last_idx;
  logic [EMPTY_OUT_W-1:0]           r_last_empty;

  logic                             w_out_vld;
  logic                             w_last;
  logic                             w_xfer;
  logic                             w_accept;

  assign w_out_vld   = (r_state == SEND_S);
  assign w_last      = (r_idx == r_last_idx);
  assign w_xfer      = w_out_vld && ast_ready_i;
  assign ast_ready_o = (r_state == IDLE_S) || (w_out_vld && w_last && ast_ready_i);
  assign w_accept    = ast_valid_i && ast_ready_o;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE_S: begin
        if (w_accept) begin
          w_state_nxt = SEND_S;
          w_idx_nxt   = '0;
        end
      end
      SEND_S: begin
        if (w_xfer) begin
          if (w_last) begin
            // A new beat may be accepted in the same cycle the last word leaves.
            w_state_nxt = w_accept ? SEND_S : IDLE_S;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE_S;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= IDLE_S;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Holding register: no reset needed, every output is gated by w_out_vld.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_data       <= ast_data_i;
      r_sop        <= ast_startofpacket_i;
      r_eop        <= ast_endofpacket_i;
      r_chan       <= ast_channel_i;
      r_last_idx   <= calc_last_idx(ast_endofpacket_i, ast_empty_i);
      r_last_empty <= calc_last_empty(ast_endofpacket_i, ast_empty_i);
    end
  end

  assign ast_valid_o         = w_out_vld;
  assign ast_data_o          = w_out_vld ? r_data[r_idx] : '0;
  assign ast_startofpacket_o = w_out_vld && r_sop && (r_idx == '0);
  assign ast_endofpacket_o   = w_out_vld && r_eop && w_last;
  assign ast_empty_o         = (w_out_vld && r_eop && w_last) ? r_last_empty : '0;
  assign ast_channel_o       = w_out_vld ? r_chan : '0;

endmodule

// File: tb/tb_ast_width_reducer.sv
// Scoreboard bench for ast_width_reducer: a byte-level model predicts narrow words per accepted beat.
module tb_ast_width_reducer;

  localparam int DIW = 256;
  localparam int DOW = 64;
  localparam int CW  = 10;
  localparam int EIW = 5;
  localparam int EOW = 3;
  localparam int IB  = DIW / 8;
  localparam int OB  = DOW / 8;
  localparam int XW  = DOW + 2 + EOW + CW;

  logic           clk;
  logic           srst_i;
  logic [DIW-1:0] ast_data_i;
  logic           ast_startofpacket_i;
  logic           ast_endofpacket_i;
  logic           ast_valid_i;
  logic [EIW-1:0] ast_empty_i;
  logic [CW-1:0]  ast_channel_i;
  logic           ast_ready_o;
  logic [DOW-1:0] ast_data_o;
  logic           ast_startofpacket_o;
  logic           ast_endofpacket_o;
  logic           ast_valid_o;
  logic [EOW-1:0] ast_empty_o;
  logic [CW-1:0]  ast_channel_o;
  logic           ast_ready_i;

  ast_width_reducer #(
    .DATA_IN_W(DIW), .EMPTY_IN_W(EIW), .CHANNEL_W(CW),
    .DATA_OUT_W(DOW), .EMPTY_OUT_W(EOW)
  ) dut (
    .clk_i(clk), .srst_i(srst_i),
    .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
    .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i), .ast_ready_o(ast_ready_o),
    .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
    .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o), .ast_ready_i(ast_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [XW-1:0] exp_q[$];
  int total;
  int bad;
  int sop_cnt;
  int eop_cnt;
  logic rdy_rand;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference: a beat is a byte string; valid bytes are cut into OB-byte words.
  task automatic model_push(input logic [DIW-1:0] d, input logic sop, input logic eop,
                            input logic [EIW-1:0] emp, input logic [CW-1:0] ch);
    int vb, nw;
    logic [DIW-1:0] sh;
    logic [EOW-1:0] we;
    vb = eop ? IB - int'(emp) : IB;
    nw = (vb + OB - 1) / OB;
    for (int w = 0; w < nw; w++) begin
      sh = d >> (w * DOW);
      we = (eop && w == nw - 1) ? EOW'(nw * OB - vb) : '0;
      exp_q.push_back({sh[DOW-1:0], sop && (w == 0), eop && (w == nw - 1), we, ch});
    end
  endtask

  task automatic monitor();
    logic [XW-1:0] act, expv, snap;
    logic prev_stall;
    prev_stall = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (srst_i) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        act = {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
        if (prev_stall) begin
          total++;
          if (!ast_valid_o || act !== snap) begin
            bad++;
            $display("FAIL stall_hold: got vld=%0b %0h expected vld=1 %0h", ast_valid_o, act, snap);
          end
        end
        total++;
        if (ast_valid_o !== (exp_q.size() != 0)) begin
          bad++;
          $display("FAIL valid: got %0b expected %0b", ast_valid_o, exp_q.size() != 0);
        end
        if (ast_valid_o && ast_ready_i && exp_q.size() != 0) begin
          expv = exp_q.pop_front();
          total++;
          if (act !== expv) begin
            bad++;
            $display("FAIL word: got %0h expected %0h", act, expv);
          end
          if (ast_startofpacket_o) sop_cnt++;
          if (ast_endofpacket_o)   eop_cnt++;
        end
        prev_stall = ast_valid_o && !ast_ready_i;
        snap = act;
        if (ast_valid_i && ast_ready_o)
          model_push(ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ast_channel_i);
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      ast_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input logic [DIW-1:0] d, input logic sop, input logic eop,
                      input logic [EIW-1:0] emp, input logic [CW-1:0] ch);
    int n;
    logic acc;
    ast_data_i = d; ast_startofpacket_i = sop; ast_endofpacket_i = eop;
    ast_empty_i = emp; ast_channel_i = ch; ast_valid_i = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = ast_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 500 cycles");
    end
    ast_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ast_valid_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DIW-1:0] rand_data();
    logic [DIW-1:0] d;
    for (int i = 0; i < DIW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    int s0, e0;
    total = 0; bad = 0; sop_cnt = 0; eop_cnt = 0;
    rdy_rand = 1'b0;
    srst_i = 1'b1; ast_valid_i = 1'b0; ast_data_i = '0; ast_startofpacket_i = 1'b0;
    ast_endofpacket_i = 1'b0; ast_empty_i = '0; ast_channel_i = '0; ast_ready_i = 1'b1;
    fork
      monitor();
      ready_drv();
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
      end
    join_none

    repeat (3) @(posedge clk);
    #1 srst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", ast_valid_o, 0);
    chk("rst_ready", ast_ready_o, 1);
    chk("rst_data", ast_data_o, 0);
    chk("rst_sop_eop", {ast_startofpacket_o, ast_endofpacket_o}, 0);
    chk("rst_empty", ast_empty_o, 0);
    chk("rst_chan", ast_channel_o, 0);
    @(posedge clk);
    #1;

    // Single full beat with word values 3..0
    send({64'd3, 64'd2, 64'd1, 64'd0}, 1'b1, 1'b1, 5'd0, 10'd7);
    drain();

    // Eop beat with 12 valid bytes: two words, ready returns on word 1
    send(rand_data(), 1'b1, 1'b1, 5'd20, 10'd3);
    @(negedge clk);
    chk("rdy_word0", ast_ready_o, 0);
    @(negedge clk);
    chk("rdy_word1", ast_ready_o, 1);
    chk("eop_word1", {ast_endofpacket_o, ast_empty_o}, {1'b1, 3'd4});
    @(posedge clk);
    #1;
    drain();

    // Three-beat packet, last beat carries one byte
    send(rand_data(), 1'b1, 1'b0, 5'd0, 10'd11);
    send(rand_data(), 1'b0, 1'b0, 5'd17, 10'd11);
    send(rand_data(), 1'b0, 1'b1, 5'd31, 10'd11);
    drain();

    // Back-to-back packets on channels 5 and 9
    s0 = sop_cnt; e0 = eop_cnt;
    send(rand_data(), 1'b1, 1'b0, 5'd0, 10'd5);
    send(rand_data(), 1'b0, 1'b1, 5'd8, 10'd5);
    send(rand_data(), 1'b1, 1'b1, 5'd0, 10'd9);
    drain();
    chk("sop_count", sop_cnt - s0, 2);
    chk("eop_count", eop_cnt - e0, 2);

    // Random traffic under 50% backpressure
    rdy_rand = 1'b1;
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(rand_data(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 10'($urandom));
    end
    drain();
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while word 2 of a 4-word beat is presented
    send(rand_data(), 1'b1, 1'b1, 5'd0, 10'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 srst_i = 1'b1;
    @(posedge clk);
    #1 srst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", ast_valid_o, 0);
    chk("rst_mid_ready", ast_ready_o, 1);
    @(posedge clk);
    #1;
    send(rand_data(), 1'b1, 1'b0, 5'd0, 10'd2);
    send(rand_data(), 1'b0, 1'b1, 5'd13, 10'd2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
